// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the EX stage and mult_div_unit
//   start/op/a/b : request driven by the EX stage
//   busy/done/dbz: status back to the hazard unit
//   hi/lo        : HI/LO registers read by MFHI/MFLO
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, input busy, done, dbz, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, dbz, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO with HI/LO registers
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mult_div_unit_if (start/op/a/b in; busy/done/dbz/hi/lo out)
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int W = WIDTH;
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   p, p_step;
    logic [W-1:0]     m, hi, lo, a_mag, b_mag;
    logic [W:0]       msum, shd, dif;
    logic             is_div, neg_q, neg_r, done, dbz, sgn, dbz_req;
    assign sgn     = bus.op[0];
    assign dbz_req = bus.op[1] && bus.b == '0;
    assign a_mag   = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
    assign b_mag   = (sgn && bus.b[W-1]) ? -bus.b : bus.b;
    // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        msum   = {1'b0, p[2*W-1:W]} + {1'b0, {W{p[0]}} & m};
        shd    = p[2*W-1:W-1];
        dif    = shd - {1'b0, m};
        p_step = is_div ? {dif[W] ? shd[W-1:0] : dif[W-1:0], p[W-2:0], ~dif[W]}
                        : {msum, p[W-1:1]};
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (bus.start && !bus.op[2] && !dbz_req) ? ITER : IDLE;
            ITER:    state_d = (cnt == '0) ? FIX : ITER;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            cnt    <= '0;
            p      <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.op == 3'b100) begin
                        hi   <= bus.a;
                        done <= 1'b1;
                    end else if (bus.op == 3'b101) begin
                        lo   <= bus.a;
                        done <= 1'b1;
                    end else if (!bus.op[2] && dbz_req) begin
                        done <= 1'b1;
                        dbz  <= 1'b1;
                    end else if (!bus.op[2]) begin
                        is_div <= bus.op[1];
                        neg_q  <= sgn & (bus.a[W-1] ^ bus.b[W-1]);
                        neg_r  <= sgn & bus.a[W-1];
                        m      <= bus.op[1] ? b_mag : a_mag;
                        p      <= {{W{1'b0}}, bus.op[1] ? a_mag : b_mag};
                        cnt    <= CNT_W'(W - 1);
                    end
                end
                ITER: begin
                    p <= p_step;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        lo <= neg_q ? -p[W-1:0] : p[W-1:0];
                        hi <= neg_r ? -p[2*W-1:W] : p[2*W-1:W];
                    end else begin
                        {hi, lo} <= neg_q ? -p : p;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = done;
    assign bus.dbz  = dbz;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule
